// File: rtl/key_debounce_if.sv
// Bundles the raw button input and the conditioned outputs of key_debounce.
// The master drives the raw key; the slave (the debouncer) drives the outputs.
interface key_debounce_if;
    logic i_key;
    logic o_level;
    logic o_press;
    logic o_release;
    logic o_long;

    modport master (
        output i_key,
        input  o_level,
        input  o_press,
        input  o_release,
        input  o_long
    );

    modport slave (
        input  i_key,
        output o_level,
        output o_press,
        output o_release,
        output o_long
    );
endinterface

// File: rtl/key_debounce.sv
// Turns a bouncing active-low push-button into a clean debounced level plus
// one-cycle press, release and long-press pulses.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int CNT_W           = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    key_debounce_if.slave  bus
);

    typedef enum logic [1:0] {
        S_UP,
        S_DOWN,
        S_LONG
    } state_t;

    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LONG_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic             sync1;
    logic             sync2;
    logic             raw_p;
    logic             toggle;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcnt_next;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             press_next;
    logic             release_next;
    logic             long_next;

    // Synchroniser idles at 1 so a reset never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= bus.i_key;
            sync2 <= sync1;
        end
    end

    assign raw_p  = ~sync2;
    assign toggle = (raw_p != level_q) && (dcnt == D_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dcnt <= '0;
        end else if ((raw_p == level_q) || (dcnt == D_LAST)) begin
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_UP;
            hcnt      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state     <= state_next;
            hcnt      <= hcnt_next;
            level_q   <= (state_next != S_UP);
            press_q   <= press_next;
            release_q <= release_next;
            long_q    <= long_next;
        end
    end

    // A release on the same cycle the hold count expires takes priority over the long pulse.
    always_comb begin
        state_next   = state;
        hcnt_next    = hcnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        case (state)
            S_UP: begin
                if (toggle) begin
                    state_next = S_DOWN;
                    press_next = 1'b1;
                    hcnt_next  = '0;
                end
            end
            S_DOWN: begin
                if (toggle) begin
                    state_next   = S_UP;
                    release_next = 1'b1;
                end else if (hcnt == L_LAST) begin
                    state_next = S_LONG;
                    long_next  = 1'b1;
                end else begin
                    hcnt_next = hcnt + 1'b1;
                end
            end
            S_LONG: begin
                if (toggle) begin
                    state_next   = S_UP;
                    release_next = 1'b1;
                end
            end
            default: begin
                state_next = S_UP;
            end
        endcase
    end

    assign bus.o_level   = level_q;
    assign bus.o_press   = press_q;
    assign bus.o_release = release_q;
    assign bus.o_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce and long-press windows.
module tb_key_debounce;

    logic i_clk;
    logic i_rst_n;
    int   checks;
    int   errors;

    key_debounce_if bus ();

    key_debounce #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10),
        .CNT_W           (32)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic lvl, input logic prs,
                             input logic rel, input logic lng);
        check_output({tag, "_level"},   bus.o_level,   lvl);
        check_output({tag, "_press"},   bus.o_press,   prs);
        check_output({tag, "_release"}, bus.o_release, rel);
        check_output({tag, "_long"},    bus.o_long,    lng);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        i_rst_n   = 1'b0;
        bus.i_key = 1'b1;

        // Reset with the key released, then idle.
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Clean press: pulse exactly on the 6th edge.
        bus.i_key = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_all("clean_press", logic'(i == 6), logic'(i == 6), 1'b0, 1'b0);
        end
        tick();
        check_all("clean_hold", 1'b1, 1'b0, 1'b0, 1'b0);

        // Short release before the long window expires: no long pulse.
        bus.i_key = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_all("clean_release", logic'(i != 6), 1'b0, logic'(i == 6), 1'b0);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_all("after_release", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Bounce 0,1,0,1 then steady 0.
        for (int i = 0; i < 4; i++) begin
            bus.i_key = logic'(i % 2);
            tick();
            check_all("bounce", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bus.i_key = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_all("bounce_press", logic'(i == 6), logic'(i == 6), 1'b0, 1'b0);
        end

        // Keep holding: one long pulse 10 cycles after the press.
        for (int i = 1; i <= 30; i++) begin
            tick();
            check_all("hold", 1'b1, 1'b0, 1'b0, logic'(i == 10));
        end
        bus.i_key = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_all("long_release", logic'(i != 6), 1'b0, logic'(i == 6), 1'b0);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_all("settle", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Glitch: three low cycles must be rejected.
        bus.i_key = 1'b0;
        tick();
        tick();
        tick();
        bus.i_key = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_all("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reach the long state, then reset while the key is still held.
        bus.i_key = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_all("pre_reset_press", logic'(i == 6), logic'(i == 6), 1'b0, 1'b0);
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_all("pre_reset_hold", 1'b1, 1'b0, 1'b0, logic'(i == 10));
        end
        i_rst_n = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("in_reset1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("in_reset2", 1'b0, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_all("post_reset_press", logic'(i == 6), logic'(i == 6), 1'b0, 1'b0);
        end
        tick();
        check_all("post_reset_hold", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
